// File: rtl/seg7_pkg.sv
// Segment codes for the active-low {g,f,e,d,c,b,a} cathodes of the common-anode display.
package seg7_pkg;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0   = 7'h40;
  localparam seg_t SEG_1   = 7'h79;
  localparam seg_t SEG_2   = 7'h24;
  localparam seg_t SEG_3   = 7'h30;
  localparam seg_t SEG_4   = 7'h19;
  localparam seg_t SEG_5   = 7'h12;
  localparam seg_t SEG_6   = 7'h02;
  localparam seg_t SEG_7   = 7'h78;
  localparam seg_t SEG_8   = 7'h00;
  localparam seg_t SEG_9   = 7'h10;
  localparam seg_t SEG_A   = 7'h08;
  localparam seg_t SEG_B   = 7'h03;
  localparam seg_t SEG_C   = 7'h46;
  localparam seg_t SEG_D   = 7'h21;
  localparam seg_t SEG_E   = 7'h06;
  localparam seg_t SEG_F   = 7'h0E;
  localparam seg_t SEG_OFF = 7'h7F;
endpackage

// File: rtl/hex7seg.sv
// Combinational nibble to active-low segment pattern decoder.
module hex7seg
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);
  always_comb begin
    seg = SEG_OFF;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end
endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed 7-segment driver; new values commit only at slot boundaries.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int PRESC_BITS = 16
) (
  input  logic        mclk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic [3:0]  blank,
  input  logic        load,
  output logic [6:0]  seg,
  output logic [3:0]  an
);
  logic [PRESC_BITS-1:0] cnt;
  logic [1:0]            dig;
  logic [15:0]           pend_val, disp_val;
  logic [3:0]            pend_blk, disp_blk;
  logic                  wrap;
  logic [3:0]            cur_nib;
  seg_t                  cur_seg;

  assign wrap    = &cnt;
  assign cur_nib = disp_val[{dig, 2'b00} +: 4];

  hex7seg u_dec (
    .nib (cur_nib),
    .seg (cur_seg)
  );

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      dig      <= 2'd0;
      pend_val <= 16'h0000;
      pend_blk <= 4'b1111;
      disp_val <= 16'h0000;
      disp_blk <= 4'b1111;
      an       <= 4'b1111;
      seg      <= SEG_OFF;
    end else begin
      cnt <= cnt + {{(PRESC_BITS-1){1'b0}}, 1'b1};
      if (load) begin
        pend_val <= value;
        pend_blk <= blank;
      end
      // A load coinciding with the slot boundary bypasses the pending buffer.
      if (wrap) begin
        dig      <= dig + 2'd1;
        disp_val <= load ? value : pend_val;
        disp_blk <= load ? blank : pend_blk;
      end
      // Output stage samples the pre-update index/buffer, giving one cycle of latency.
      if (disp_blk[dig]) begin
        an  <= 4'b1111;
        seg <= SEG_OFF;
      end else begin
        an  <= ~(4'b0001 << dig);
        seg <= cur_seg;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with 4-cycle digit slots.
module tb_seg7_scan;
  logic        mclk;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  blank;
  logic        load;
  logic [6:0]  seg;
  logic [3:0]  an;

  int ncmp = 0;
  int nerr = 0;

  seg7_scan #(.PRESC_BITS(2)) dut (
    .mclk  (mclk),
    .rst_n (rst_n),
    .value (value),
    .blank (blank),
    .load  (load),
    .seg   (seg),
    .an    (an)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input logic [3:0] ea, input logic [6:0] es);
    ncmp++;
    assert (an === ea) else begin
      nerr++;
      $error("FAIL %s an: got %b want %b", tag, an, ea);
    end
    ncmp++;
    assert (seg === es) else begin
      nerr++;
      $error("FAIL %s seg: got %h want %h", tag, seg, es);
    end
  endtask

  // Advance one edge, then sample away from it.
  task automatic step(input string tag, input logic [3:0] ea, input logic [6:0] es);
    @(posedge mclk);
    #1;
    chk(tag, ea, es);
  endtask

  task automatic slot(input string tag, input logic [3:0] ea, input logic [6:0] es);
    for (int i = 0; i < 4; i++) step(tag, ea, es);
  endtask

  initial begin
    rst_n = 1'b0;
    value = 16'h0000;
    blank = 4'b0000;
    load  = 1'b0;

    // Reset held
    @(posedge mclk); #1;
    chk("reset_hold", 4'b1111, 7'h7F);
    @(posedge mclk); #1;
    chk("reset_hold2", 4'b1111, 7'h7F);
    @(negedge mclk);
    rst_n = 1'b1;

    // No load: dark for 32 cycles (edges 1..32)
    for (int i = 0; i < 32; i++) step("idle_dark", 4'b1111, 7'h7F);

    // Basic scan: load 12AF at edge 33, commit at wrap edge 36
    value = 16'h12AF; blank = 4'b0000; load = 1'b1;
    step("basic_pre", 4'b1111, 7'h7F);
    load = 1'b0;
    step("basic_pre", 4'b1111, 7'h7F);
    step("basic_pre", 4'b1111, 7'h7F);
    step("basic_wrapedge", 4'b1111, 7'h7F);
    slot("basic_d1", 4'b1101, 7'h08);
    slot("basic_d2", 4'b1011, 7'h24);
    slot("basic_d3", 4'b0111, 7'h79);
    slot("basic_d0", 4'b1110, 7'h0E);

    // Blanking: load 0007/1110 during digit-1 slot, commit at edge 56
    value = 16'h0007; blank = 4'b1110; load = 1'b1;
    step("blank_old", 4'b1101, 7'h08);
    load = 1'b0;
    step("blank_old", 4'b1101, 7'h08);
    step("blank_old", 4'b1101, 7'h08);
    step("blank_old", 4'b1101, 7'h08);
    slot("blank_d2", 4'b1111, 7'h7F);
    slot("blank_d3", 4'b1111, 7'h7F);
    slot("blank_d0", 4'b1110, 7'h78);
    slot("blank_d1", 4'b1111, 7'h7F);

    // Mid-slot load while digit 2 is up
    step("mid_old", 4'b1111, 7'h7F);
    value = 16'hFFFF; blank = 4'b0000; load = 1'b1;
    step("mid_old", 4'b1111, 7'h7F);
    load = 1'b0;
    step("mid_old", 4'b1111, 7'h7F);
    step("mid_old", 4'b1111, 7'h7F);
    slot("mid_d3", 4'b0111, 7'h0E);
    slot("mid_d0", 4'b1110, 7'h0E);

    // Load exactly on the wrap cycle (cnt==3)
    step("wrapld_old", 4'b1101, 7'h0E);
    step("wrapld_old", 4'b1101, 7'h0E);
    step("wrapld_old", 4'b1101, 7'h0E);
    value = 16'h8888; blank = 4'b0000; load = 1'b1;
    step("wrapld_old", 4'b1101, 7'h0E);
    load = 1'b0;
    slot("wrapld_d2", 4'b1011, 7'h00);

    // Async reset mid-scan, between edges
    step("arst_pre", 4'b0111, 7'h00);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_immediate", 4'b1111, 7'h7F);
    @(negedge mclk);
    @(negedge mclk);
    chk("arst_held", 4'b1111, 7'h7F);
    rst_n = 1'b1;

    // Buffers cleared: stays dark across two wraps
    for (int i = 0; i < 8; i++) step("arst_dark", 4'b1111, 7'h7F);

    // Scan restarted at digit 0: this load commits entering digit 3
    value = 16'h4321; blank = 4'b0000; load = 1'b1;
    step("arst_ld", 4'b1111, 7'h7F);
    load = 1'b0;
    step("arst_ld", 4'b1111, 7'h7F);
    step("arst_ld", 4'b1111, 7'h7F);
    step("arst_ld", 4'b1111, 7'h7F);
    slot("arst_d3", 4'b0111, 7'h19);
    slot("arst_d0", 4'b1110, 7'h79);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
